// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin owner of the shared 2-digit 7-segment display.
// The granted module drives the pins through a 1-cycle register stage. After a done
// pulse the display shows "--" for HOLD_CYCLES, then blanks for BLANK_CYCLES before
// the next arbitration.
// Optional feature: define SCHED_TIMEOUT_EN to force-release an owner after
// MAX_RUN_CYCLES RUN cycles and raise the sticky timeout flag.
module seg_display_scheduler #(
    parameter int unsigned     N_REQ          = 4,
    parameter int unsigned     HOLD_CYCLES    = 100_000_000,
    parameter int unsigned     BLANK_CYCLES   = 2,
    parameter longint unsigned MAX_RUN_CYCLES = 64'd6_000_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [2*N_REQ-1:0]   src_seg_en,
    input  logic [8*N_REQ-1:0]   src_seg_out,
    output logic [N_REQ-1:0]     grant,
    output logic [1:0]           seg_en,
    output logic [7:0]           seg_out,
    output logic                 busy,
    output logic [2:0]           cur_id,
    output logic                 timeout
);

    localparam int unsigned ID_W    = 3;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2,
        S_BLANK = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [1:0]           seg_en_q, seg_en_d;
    logic [7:0]           seg_out_q, seg_out_d;
    logic                 busy_q, busy_d;

    logic                 win_valid_c;
    logic [ID_W-1:0]      win_id_c;
    logic                 own_req_c;
    logic                 own_done_c;
    logic [1:0]           own_seg_en_c;
    logic [7:0]           own_seg_out_c;
    logic                 run_expire_c;
    logic                 timeout_hit_c;
    int unsigned          idx;

    // Round-robin search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        win_valid_c = 1'b0;
        win_id_c    = '0;
        idx         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!win_valid_c && (idx == j) && req[j]) begin
                    win_valid_c = 1'b1;
                    win_id_c    = ID_W'(j);
                end
            end
        end
    end

    // Select the current owner's request, done and display slices.
    always_comb begin
        own_req_c     = 1'b0;
        own_done_c    = 1'b0;
        own_seg_en_c  = '0;
        own_seg_out_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (cur_id_q == ID_W'(i)) begin
                own_req_c     = req[i];
                own_done_c    = done[i];
                own_seg_en_c  = src_seg_en[2*i +: 2];
                own_seg_out_c = src_seg_out[8*i +: 8];
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned RUN_W = (MAX_RUN_CYCLES > 1) ? $clog2(MAX_RUN_CYCLES) : 1;

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             timeout_q, timeout_d;

    assign run_expire_c = (run_cnt_q == RUN_W'(MAX_RUN_CYCLES - 64'd1));
    assign run_cnt_d    = (state_q == S_RUN && state_d == S_RUN) ? run_cnt_q + RUN_W'(1) : '0;
    assign timeout_d    = timeout_q | timeout_hit_c;
    assign timeout      = timeout_q;

    // RUN-length counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_max;

    assign run_expire_c = 1'b0;
    assign timeout      = 1'b0;
    assign unused_max   = ^MAX_RUN_CYCLES;
`endif

    // State, pointer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cur_id_q    <= '0;
            hold_cnt_q  <= '0;
            blank_cnt_q <= '0;
            grant_q     <= '0;
            seg_en_q    <= '0;
            seg_out_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            hold_cnt_q  <= hold_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            grant_q     <= grant_d;
            seg_en_q    <= seg_en_d;
            seg_out_q   <= seg_out_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: done beats release, release beats timeout; counters clear on entry.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cur_id_d      = cur_id_q;
        hold_cnt_d    = '0;
        blank_cnt_d   = '0;
        timeout_hit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_valid_c) begin
                    state_d  = S_RUN;
                    cur_id_d = win_id_c;
                end
            end
            S_RUN: begin
                if (own_done_c) begin
                    state_d = S_HOLD;
                end else if (!own_req_c) begin
                    state_d = S_BLANK;
                end else if (run_expire_c) begin
                    state_d       = S_BLANK;
                    timeout_hit_c = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_BLANK;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_BLANK: begin
                if (blank_cnt_q == BLANK_W'(BLANK_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_BLANK && state_q != S_BLANK) begin
            ptr_d = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);
        end
    end

    // Output values registered alongside the state they belong to.
    always_comb begin
        grant_d   = '0;
        seg_en_d  = '0;
        seg_out_d = '0;
        busy_d    = (state_d != S_IDLE);
        case (state_d)
            S_RUN: begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    grant_d[i] = (cur_id_d == ID_W'(i));
                end
                if (state_q == S_RUN) begin
                    seg_en_d  = own_seg_en_c;
                    seg_out_d = own_seg_out_c;
                end
            end
            S_HOLD: begin
                seg_en_d  = 2'b11;
                seg_out_d = 8'b0000_0010;
            end
            default: ;
        endcase
    end

    assign grant   = grant_q;
    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;
    assign busy    = busy_q;
    assign cur_id  = cur_id_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: stimulus pushes expected grants and
// post-grant episodes (hold/blank lengths, timeout flag); a monitor pops and compares.
module tb_seg_display_scheduler;

    localparam int unsigned N      = 4;
    localparam int unsigned HOLD   = 5;
    localparam int unsigned BLANK  = 2;
    localparam int unsigned MAXRUN = 20;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [7:0]  src_seg_en;
    logic [31:0] src_seg_out;
    logic [3:0]  grant;
    logic [1:0]  seg_en;
    logic [7:0]  seg_out;
    logic        busy;
    logic [2:0]  cur_id;
    logic        timeout;

    seg_display_scheduler #(
        .N_REQ          (N),
        .HOLD_CYCLES    (HOLD),
        .BLANK_CYCLES   (BLANK),
        .MAX_RUN_CYCLES (64'(MAXRUN))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .src_seg_en  (src_seg_en),
        .src_seg_out (src_seg_out),
        .grant       (grant),
        .seg_en      (seg_en),
        .seg_out     (seg_out),
        .busy        (busy),
        .cur_id      (cur_id),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [2:0] id;
    } exp_grant_t;

    typedef struct {
        int hold;
        int blank;
        int run;
        bit to;
    } exp_ep_t;

    exp_grant_t gq[$];
    exp_ep_t    eq[$];
    int         checks   = 0;
    int         failures = 0;
    int         ptr_m    = 0;
    int         own_m    = 0;
    bit         to_m     = 1'b0;
    bit         mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic randomize_src();
        src_seg_en  = 8'($urandom);
        src_seg_out = $urandom;
    endtask

    // Reference arbitration: first requester at or after the model pointer.
    task automatic start_req(input logic [3:0] v);
        exp_grant_t e;
        int w;
        int k;
        req = v;
        w   = -1;
        for (int i = 0; i < int'(N); i++) begin
            k = (ptr_m + i) % int'(N);
            if (w < 0 && v[k]) w = k;
        end
        own_m = w;
        e.g   = 4'(1) << w;
        e.id  = 3'(w);
        gq.push_back(e);
    endtask

    // kind: 0 done, 1 done with release, 2 release only, 3 run into timeout.
    task automatic run_owner(input int kind, input int extra, input bit rand_src, input logic [3:0] dnoise);
        int         w;
        int         waited;
        exp_ep_t    ep;
        logic [3:0] oh;
        w  = own_m;
        oh = 4'(1) << w;
        waited = 0;
        @(negedge clk);
        while (grant == 4'b0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        if (grant == 4'b0) begin
            checks++;
            failures++;
            $display("FAIL grant_wait: got no grant after %0d cycles, expected %b", waited, oh);
            return;
        end
        repeat (extra) begin
            @(posedge clk); #1;
            if (rand_src) randomize_src();
            done = 4'($urandom) & ~oh;
            req  = (4'($urandom) & ~oh) | oh;
        end
        @(posedge clk); #1;
        if (rand_src) randomize_src();
        case (kind)
            0: begin
                done = oh | (dnoise & ~oh);
                req  = req | oh;
                ep   = '{int'(HOLD), int'(BLANK), -1, to_m};
            end
            1: begin
                done = oh;
                req  = req & ~oh;
                ep   = '{int'(HOLD), int'(BLANK), -1, to_m};
            end
            2: begin
                done = dnoise & ~oh;
                req  = req & ~oh;
                ep   = '{0, int'(BLANK), -1, to_m};
            end
            default: begin
                done = 4'b0;
                req  = req | oh;
                to_m = 1'b1;
                ep   = '{0, int'(BLANK), int'(MAXRUN), 1'b1};
            end
        endcase
        eq.push_back(ep);
        if (kind == 3) begin
            waited = 0;
            @(negedge clk);
            while (grant != 4'b0 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (grant != 4'b0) begin
                checks++;
                failures++;
                $display("FAIL timeout_release: grant still %b after %0d cycles, expected 0", grant, waited);
            end
        end
        ptr_m = (w + 1) % int'(N);
        @(posedge clk); #1;
        done = 4'b0;
    endtask

    // Monitor: pops expected grants on each new grant and expected episodes at return to idle.
    initial begin : monitor
        logic [3:0] pg;
        logic [2:0] pid;
        logic [1:0] pse;
        logic [7:0] pso;
        int         run_cnt;
        int         ep_run;
        int         hold_len;
        int         blank_len;
        int         bad;
        bit         in_ep;
        exp_grant_t eg;
        exp_ep_t    ee;
        pg = 4'b0; pid = 3'b0; pse = 2'b0; pso = 8'b0;
        run_cnt = 0; ep_run = 0; hold_len = 0; blank_len = 0; bad = 0; in_ep = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pg    = 4'b0;
                in_ep = 1'b0;
            end else begin
                chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
                if (grant != 4'b0 && pg == 4'b0) begin
                    if (gq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL grant_unexpected: got %b, expected no grant", grant);
                    end else begin
                        eg = gq.pop_front();
                        chk("grant", 32'(grant), 32'(eg.g));
                        chk("cur_id", 32'(cur_id), 32'(eg.id));
                        chk("grant_first_seg", 32'({seg_en, seg_out}), 32'd0);
                    end
                    chk("busy_run", 32'(busy), 32'd1);
                    run_cnt = 1;
                end else if (grant != 4'b0) begin
                    run_cnt++;
                    chk("seg_en_pipe", 32'(seg_en), 32'(pse));
                    chk("seg_out_pipe", 32'(seg_out), 32'(pso));
                    chk("cur_id_stable", 32'(cur_id), 32'(pid));
                end
                if (grant == 4'b0 && pg != 4'b0) begin
                    in_ep     = 1'b1;
                    hold_len  = 0;
                    blank_len = 0;
                    bad       = 0;
                    ep_run    = run_cnt;
                end
                if (in_ep && grant == 4'b0) begin
                    if (busy && seg_en == 2'b11 && seg_out == 8'h02 && blank_len == 0) begin
                        hold_len++;
                    end else if (busy && seg_en == 2'b00 && seg_out == 8'h00) begin
                        blank_len++;
                    end else if (!busy) begin
                        in_ep = 1'b0;
                        chk("idle_seg", 32'({seg_en, seg_out}), 32'd0);
                        if (eq.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL episode_unexpected: got episode hold=%0d blank=%0d, expected none", hold_len, blank_len);
                        end else begin
                            ee = eq.pop_front();
                            chk("hold_len", 32'(hold_len), 32'(ee.hold));
                            chk("blank_len", 32'(blank_len), 32'(ee.blank));
                            chk("episode_bad_pattern", 32'(bad), 32'd0);
                            chk("timeout_flag", 32'(timeout), 32'(ee.to));
                            if (ee.run >= 0) chk("run_len", 32'(ep_run), 32'(ee.run));
                        end
                    end else begin
                        bad++;
                    end
                end
            end
            pg  = grant;
            pid = cur_id;
            pse = src_seg_en[2*cur_id +: 2];
            pso = src_seg_out[8*cur_id +: 8];
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int waited;
        rst = 1'b0; req = 4'b1111; done = 4'b0; src_seg_en = 8'b0; src_seg_out = 32'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_seg_en", 32'(seg_en), 32'd0);
        chk("rst_seg_out", 32'(seg_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        start_req(4'b1111);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("grant_after_reset", 32'(grant), 32'b0001);

        run_owner(0, 1, 1'b1, 4'b1000);
        src_seg_en  = 8'b0001_0000;
        src_seg_out = 32'h00FC_0000;
        start_req(4'b0100); run_owner(0, 2, 1'b0, 4'b0000);
        start_req(4'b1111); run_owner(0, 0, 1'b1, 4'b0000);
        start_req(4'b1111); run_owner(0, 0, 1'b1, 4'b0000);
        start_req(4'b1111); run_owner(1, 1, 1'b1, 4'b0000);
        start_req(4'b0010); run_owner(2, 1, 1'b1, 4'b0101);
`ifdef SCHED_TIMEOUT_EN
        start_req(4'b0001); run_owner(3, 0, 1'b1, 4'b0000);
`endif
        for (int t = 0; t < 60; t++) begin
            start_req(4'($urandom_range(1, 15)));
            run_owner(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), 1'b1, 4'($urandom));
        end

        req = 4'b0;
        waited = 0;
        @(negedge clk);
        while ((busy || grant != 4'b0) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (busy || grant != 4'b0) begin
            checks++;
            failures++;
            $display("FAIL final_idle: got busy=%0b grant=%b, expected idle", busy, grant);
        end
        repeat (2) @(negedge clk);
        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("episode_queue_drained", 32'(eq.size()), 32'd0);
        chk("timeout_sticky", 32'(timeout), 32'(to_m));

        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_timeout", 32'(timeout), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_grant", 32'(grant), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
